e20_run_ctrl: RTL
=================

E20_RUN_CTRL -- requirements
Module: e20_run_ctrl

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 100000, meaning the RUN-phase watchdog limit in clock cycles.
REQ-002 SHALL have parameter RESET_HOLD, default 5, meaning the number of cycles cpu_reset is held after load.
REQ-003 SHALL have parameter DUMP_WORDS, default 128, meaning the number of RAM words streamed out after the run.
REQ-004 clock  in  1  sole clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ld_valid/ld_ready  in/out  1/1  load-word handshake.
REQ-007 ld_addr/ld_data/ld_last  in  13/16/1  load word address, data, and final-word flag.
REQ-008 restart  in  1  from DONE, return to LOAD.
REQ-009 cpu_reset  out  1  processor reset.
REQ-010 cpu_halt  in  1  processor halt indication.
REQ-011 mem_sel  out  1  1 = controller owns the RAM port; 0 = processor owns it.
REQ-012 mem_we/mem_addr/mem_wdata  out  1/13/16  controller RAM write strobe, address, and write data.
REQ-013 mem_rdata  in  16  RAM read data, valid one cycle after mem_addr.
REQ-014 dump_valid/dump_ready  out/in  1/1  dump-stream handshake.
REQ-015 dump_addr/dump_data  out  7/16  dump word index and value.
REQ-016 status  out  2  00 loading, 01 running, 10 halted, 11 timeout.
REQ-017 cycles  out  32  RUN-phase cycle count.

Function
REQ-018 SHALL implement states LOAD, HOLD, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-019 LOAD SHALL drive ld_ready=1, mem_sel=1, cpu_reset=1, and mem_we=ld_valid combinationally, with mem_addr=ld_addr and mem_wdata=ld_data.
REQ-020 In LOAD, a transfer with ld_last=1 SHALL write that word and enter HOLD on the next cycle; a zero-length load is not supported.
REQ-021 Outside LOAD, ld_ready SHALL be 0 and ld_valid SHALL be ignored.
REQ-022 HOLD SHALL keep cpu_reset=1 and mem_sel=1 for exactly RESET_HOLD cycles, clear cycles to 0, then enter RUN.
REQ-023 RUN SHALL drive cpu_reset=0, mem_sel=0, and mem_we=0, and SHALL increment cycles once per RUN cycle.
REQ-024 In RUN, cpu_halt=1 SHALL set status=10 and enter DUMP_RD.
REQ-025 In RUN, cycles reaching MAX_CYCLES SHALL set status=11 and enter DUMP_RD.
REQ-026 If halt and the watchdog limit coincide in the same cycle, halt SHALL win and status SHALL be 10.
REQ-027 cycles SHALL freeze on RUN exit and hold until the next HOLD.
REQ-028 All states except RUN SHALL assert cpu_reset=1 and mem_sel=1, so a timed-out processor is frozen before dump.
REQ-029 DUMP_RD SHALL drive mem_addr=index (zero-extended), mem_we=0, then enter DUMP_OUT.
REQ-030 DUMP_OUT SHALL register mem_rdata into dump_data and assert dump_valid with dump_addr=index.
REQ-031 dump_data and dump_addr SHALL be held stable while dump_valid=1 and dump_ready=0.
REQ-032 On dump_valid&dump_ready, if index=DUMP_WORDS-1 the block SHALL enter DONE; otherwise it SHALL increment index and return to DUMP_RD.
REQ-033 Sustained dump throughput SHALL be 1 word per 2 cycles when dump_ready=1.
REQ-034 DONE SHALL hold status and cycles, with dump_valid=0.
REQ-035 In DONE, restart=1 SHALL enter LOAD with status=00; restart SHALL be ignored in all other states.

Reset
REQ-036 Synchronous reset SHALL force state=LOAD, status=00, cycles=0, index=0, cpu_reset=1, mem_sel=1, mem_we=0, dump_valid=0, and ld_ready=1 on the first post-reset cycle.
REQ-037 Reset asserted mid-RUN or mid-DUMP SHALL abort immediately, with no further dump handshakes and no RAM writes.
REQ-038 RAM contents SHALL NOT be cleared by this block.

Structure
REQ-039 A shared package e20_pkg SHALL hold the state enumeration, the status codes, ADDR_W=13, and DATA_W=16.
REQ-040 One sub-module, e20_run_watchdog, SHALL implement the 32-bit cycle counter with clear, enable, and limit-compare.

Verification
REQ-041 Load 3 words (0:0x2001, 1:0x4082, 2:0x4000 with ld_last), processor halts after 7 RUN cycles -> status=10, cycles=7, dump word0=0x2001.
REQ-042 cpu_halt never asserted with MAX_CYCLES=50 -> status=11, cycles=50, cpu_reset=1 from the cycle after the limit.
REQ-043 cpu_halt and the watchdog limit on the same cycle -> status=10.
REQ-044 dump_ready toggled 0/1 each cycle -> exactly 128 transfers, dump_addr 0..127 in order, data stable while stalled.
REQ-045 reset pulsed during DUMP at index 40 -> next cycle shows state LOAD, dump_valid=0, ld_ready=1.
REQ-046 restart in DONE, then a second load -> cycles re-counts from 0, status 00->01->10.

Source files
------------

// File: rtl/e20_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e20_pkg
// Description : Shared types and constants for the e20 run controller:
//               controller state enumeration, status codes and bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package e20_pkg;

    localparam int ADDR_W = 13;   // RAM word address width
    localparam int DATA_W = 16;   // RAM word width
    localparam int IDX_W  = 7;    // dump word index width

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        HOLD     = 3'd1,
        RUN      = 3'd2,
        DUMP_RD  = 3'd3,
        DUMP_OUT = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        STATUS_LOADING = 2'b00,
        STATUS_RUNNING = 2'b01,
        STATUS_HALTED  = 2'b10,
        STATUS_TIMEOUT = 2'b11
    } status_t;

endpackage : e20_pkg
`default_nettype wire

// File: rtl/e20_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : e20_run_ctrl_if
// Description : Bus bundle between the run controller and its environment.
//               ld_*   : load-word handshake (valid/ready, addr, data, last)
//               mem_*  : controller RAM port (sel, we, addr, wdata, rdata)
//               dump_* : dump stream handshake (valid/ready, addr, data)
//               master : controller side; slave : environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface e20_run_ctrl_if;
    import e20_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        input  ld_valid, ld_addr, ld_data, ld_last, mem_rdata, dump_ready,
        output ld_ready, mem_sel, mem_we, mem_addr, mem_wdata,
               dump_valid, dump_addr, dump_data
    );

    modport slave (
        output ld_valid, ld_addr, ld_data, ld_last, mem_rdata, dump_ready,
        input  ld_ready, mem_sel, mem_we, mem_addr, mem_wdata,
               dump_valid, dump_addr, dump_data
    );

endinterface : e20_run_ctrl_if
`default_nettype wire

// File: rtl/e20_run_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : e20_run_watchdog
// Description : 32-bit RUN-phase cycle counter with clear, enable and limit
//               compare.
//               clock/reset : clock, synchronous active-high reset
//               i_clear     : force count to zero (has priority)
//               i_enable    : count one per cycle
//               o_count     : current count
//               o_limit_hit : this enabled cycle brings count to MAX_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
module e20_run_watchdog #(
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        i_clear,
    input  wire logic        i_enable,
    output logic [31:0]      o_count,
    output logic             o_limit_hit
);

    logic [31:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Flag the cycle whose increment lands on the limit, so the caller can
    // leave RUN on the same edge that makes the count equal MAX_CYCLES.
    assign o_limit_hit = i_enable && (r_count == MAX_CYCLES - 32'd1);
    assign o_count     = r_count;

endmodule : e20_run_watchdog
`default_nettype wire

// File: rtl/e20_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : e20_run_ctrl
// Description : Load / run / dump sequencer for a small processor.
//               Loads program words into RAM, holds the processor in reset,
//               lets it run until halt or watchdog timeout, then streams the
//               first DUMP_WORDS RAM words out.
//               clock, reset : clock, synchronous active-high reset
//               bus          : ld_*, mem_*, dump_* bundle (master side)
//               restart      : DONE -> LOAD
//               cpu_reset    : processor reset
//               cpu_halt     : processor halt indication
//               status       : 00 loading, 01 running, 10 halted, 11 timeout
//               cycles       : RUN-phase cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module e20_run_ctrl
    import e20_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 100000,
    parameter int unsigned RESET_HOLD = 5,
    parameter int unsigned DUMP_WORDS = 128
) (
    input  wire logic        clock,
    input  wire logic        reset,
    e20_run_ctrl_if.master   bus,
    input  wire logic        restart,
    output logic             cpu_reset,
    input  wire logic        cpu_halt,
    output logic [1:0]       status,
    output logic [31:0]      cycles
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DUMP_WORDS - 1);

    state_t            r_state;
    status_t           r_status;
    logic [IDX_W-1:0]  r_index;
    logic [31:0]       r_hold_cnt;
    logic              r_ld_ready;
    logic              r_own;          // controller owns RAM, cpu held in reset
    logic              r_dump_valid;
    logic              r_dump_held;    // r_dump_data holds the current word
    logic [DATA_W-1:0] r_dump_data;

    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_limit_hit;
    logic [31:0]       w_count;

    assign w_wd_clear  = (r_state == HOLD);
    assign w_wd_enable = (r_state == RUN);

    e20_run_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_wd_clear),
        .i_enable    (w_wd_enable),
        .o_count     (w_count),
        .o_limit_hit (w_limit_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= LOAD;
            r_status     <= STATUS_LOADING;
            r_index      <= '0;
            r_hold_cnt   <= '0;
            r_ld_ready   <= 1'b1;
            r_own        <= 1'b1;
            r_dump_valid <= 1'b0;
            r_dump_held  <= 1'b0;
            r_dump_data  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (bus.ld_valid && bus.ld_last) begin
                        r_state    <= HOLD;
                        r_ld_ready <= 1'b0;
                        r_hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == RESET_HOLD - 32'd1) begin
                        r_state  <= RUN;
                        r_own    <= 1'b0;
                        r_status <= STATUS_RUNNING;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                RUN: begin
                    // Halt takes precedence over a coincident watchdog hit.
                    if (cpu_halt || w_limit_hit) begin
                        r_state  <= DUMP_RD;
                        r_own    <= 1'b1;
                        r_status <= cpu_halt ? STATUS_HALTED : STATUS_TIMEOUT;
                        r_index  <= '0;
                    end
                end
                DUMP_RD: begin
                    r_state      <= DUMP_OUT;
                    r_dump_valid <= 1'b1;
                    r_dump_held  <= 1'b0;
                end
                DUMP_OUT: begin
                    // Read data arrives during the first DUMP_OUT cycle; it is
                    // captured then and served from the register while stalled.
                    if (!r_dump_held) begin
                        r_dump_data <= bus.mem_rdata;
                        r_dump_held <= 1'b1;
                    end
                    if (bus.dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_index == c_LAST_IDX) begin
                            r_state <= DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= DUMP_RD;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        r_state    <= LOAD;
                        r_status   <= STATUS_LOADING;
                        r_ld_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    // r_ld_ready is high exactly in LOAD, so it doubles as the LOAD decode.
    assign bus.ld_ready   = r_ld_ready;
    assign bus.mem_sel    = r_own;
    assign bus.mem_we     = r_ld_ready & bus.ld_valid;
    assign bus.mem_addr   = r_ld_ready ? bus.ld_addr
                                       : {{(ADDR_W - IDX_W){1'b0}}, r_index};
    assign bus.mem_wdata  = bus.ld_data;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_addr  = r_index;
    assign bus.dump_data  = r_dump_held ? r_dump_data : bus.mem_rdata;

    assign cpu_reset = r_own;
    assign status    = r_status;
    assign cycles    = w_count;

endmodule : e20_run_ctrl
`default_nettype wire
